sram_like_arbiter: RTL and testbench



---
 rtl/sram_like_arbiter_pkg.sv | 13 +
 rtl/sram_like_arbiter_if.sv | 34 +++
 rtl/sram_like_order_fifo.sv | 51 +++++
 rtl/sram_like_arbiter.sv | 119 +++++++++++
 tb/tb_sram_like_arbiter.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/sram_like_arbiter_pkg.sv
// Shared constants and types for the SRAM-like N:1 arbiter.
package sram_like_arbiter_pkg;
  localparam int SIZE_W    = 2;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  typedef enum logic {GRANT_FREE, GRANT_LOCKED} grant_state_e;

  // Width of a master index stored in the order FIFO.
  function automatic int order_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_like_arbiter_if.sv
// SRAM-like bus bundle: N master channels on one side, one slave channel on the other.
interface sram_like_arbiter_if
  import sram_like_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic [NUM_MASTERS-1:0]              m_req, m_wr, m_addr_ok, m_data_ok;
  logic [NUM_MASTERS-1:0][SIZE_W-1:0]  m_size;
  logic [NUM_MASTERS-1:0][STRB_W-1:0]  m_wstrb;
  logic [NUM_MASTERS-1:0][ADDR_W-1:0]  m_addr;
  logic [NUM_MASTERS-1:0][DATA_W-1:0]  m_wdata;
  logic [DATA_W-1:0]                   m_rdata;

  logic              s_req, s_wr, s_addr_ok, s_data_ok;
  logic [SIZE_W-1:0] s_size;
  logic [STRB_W-1:0] s_wstrb;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata, s_rdata;

  // Arbiter side: masters the downstream slave, serves the upstream channels.
  modport master (
    input  m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata, s_addr_ok, s_data_ok, s_rdata,
    output m_addr_ok, m_data_ok, m_rdata, s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata
  );
  // Environment side: the upstream channels plus the downstream slave.
  modport slave (
    output m_req, m_wr, m_size, m_wstrb, m_addr, m_wdata, s_addr_ok, s_data_ok, s_rdata,
    input  m_addr_ok, m_data_ok, m_rdata, s_req, s_wr, s_size, s_wstrb, s_addr, s_wdata
  );
endinterface

// File: rtl/sram_like_order_fifo.sv
// Synchronous FIFO of master indices recording address-acceptance order.
module sram_like_order_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [PTR_W-1:0]            wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]              count_q;
  logic                        do_push, do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/sram_like_arbiter.sv
// N-master to 1-slave SRAM-like arbiter with in-order response routing.
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS     = 2,
  parameter int ADDR_W          = 32,
  parameter int DATA_W          = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ARB_MODE        = ARB_FIXED
) (
  input  logic                             clk,
  input  logic                             reset,
  sram_like_arbiter_if.master              bus,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                             err_o
);
  localparam int IDX_W = order_idx_w(NUM_MASTERS);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  grant_state_e     state_q, state_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d, rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] free_gnt, grant, head_idx;
  logic [CNT_W-1:0] count;
  logic             err_q, err_d, rr_found, any_req, withdrawn;
  logic             s_req, hs, pop, fifo_full, fifo_empty;

  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_MASTERS) s -= NUM_MASTERS;
    return IDX_W'(s);
  endfunction

  always_comb begin
    free_gnt = '0;
    rr_found = 1'b0;
    if (ARB_MODE == ARB_RR) begin
      for (int k = 0; k < NUM_MASTERS; k++) begin
        if (!rr_found && bus.m_req[wrap_add(rr_ptr_q, k)]) begin
          free_gnt = wrap_add(rr_ptr_q, k);
          rr_found = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUM_MASTERS; i++)
        if (bus.m_req[i]) free_gnt = IDX_W'(i);
    end
  end

  assign grant     = (state_q == GRANT_LOCKED) ? lock_idx_q : free_gnt;
  assign any_req   = (state_q == GRANT_LOCKED) ? bus.m_req[lock_idx_q] : |bus.m_req;
  assign withdrawn = (state_q == GRANT_LOCKED) & ~bus.m_req[lock_idx_q];

  // Reset masks every visible output, not just the registered ones.
  assign s_req = ~reset & any_req & ~fifo_full;
  assign hs    = s_req & bus.s_addr_ok;
  assign pop   = ~reset & bus.s_data_ok & ~fifo_empty;

  assign bus.s_req   = s_req;
  assign bus.s_wr    = bus.m_wr[grant];
  assign bus.s_size  = bus.m_size[grant];
  assign bus.s_wstrb = bus.m_wstrb[grant];
  assign bus.s_addr  = bus.m_addr[grant];
  assign bus.s_wdata = bus.m_wdata[grant];
  assign bus.m_rdata = bus.s_rdata;

  always_comb begin
    bus.m_addr_ok = '0;
    bus.m_data_ok = '0;
    if (hs)  bus.m_addr_ok[grant]    = 1'b1;
    if (pop) bus.m_data_ok[head_idx] = 1'b1;
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    err_d      = err_q;
    unique case (state_q)
      GRANT_FREE: if (s_req && !bus.s_addr_ok) begin
        state_d    = GRANT_LOCKED;
        lock_idx_d = grant;
      end
      GRANT_LOCKED: if (hs || withdrawn) state_d = GRANT_FREE;
      default: state_d = GRANT_FREE;
    endcase
    if (hs && ARB_MODE == ARB_RR) rr_ptr_d = wrap_add(grant, 1);
    if (withdrawn || (bus.s_data_ok && fifo_empty)) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= GRANT_FREE;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      err_q      <= err_d;
    end
  end

  sram_like_order_fifo #(.WIDTH(IDX_W), .DEPTH(MAX_OUTSTANDING)) u_order_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (hs),
    .data_i  (grant),
    .pop_i   (pop),
    .data_o  (head_idx),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign outstanding_o = reset ? '0 : count;
  assign err_o         = ~reset & err_q;
endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: fixed-priority and round-robin arbiters driven by the same stimulus.
module tb_sram_like_arbiter;
  import sram_like_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  m_req = '0;
  logic        s_addr_ok = 1'b0, s_data_ok = 1'b0;
  logic [31:0] s_rdata = '0;
  logic [2:0]  out_fx, out_rr;
  logic        err_fx, err_rr;
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;

  sram_like_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32)) bus_fx ();
  sram_like_arbiter_if #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32)) bus_rr ();

  assign bus_fx.m_req = m_req;            assign bus_rr.m_req = m_req;
  assign bus_fx.m_wr = 2'b10;             assign bus_rr.m_wr = 2'b10;
  assign bus_fx.m_size = {2'd1, 2'd2};    assign bus_rr.m_size = {2'd1, 2'd2};
  assign bus_fx.m_wstrb = {4'hf, 4'h0};   assign bus_rr.m_wstrb = {4'hf, 4'h0};
  assign bus_fx.m_addr = {32'h8000_0100, 32'h1c00_0000};
  assign bus_rr.m_addr = {32'h8000_0100, 32'h1c00_0000};
  assign bus_fx.m_wdata = {32'hcafe_f00d, 32'h0};
  assign bus_rr.m_wdata = {32'hcafe_f00d, 32'h0};
  assign bus_fx.s_addr_ok = s_addr_ok;    assign bus_rr.s_addr_ok = s_addr_ok;
  assign bus_fx.s_data_ok = s_data_ok;    assign bus_rr.s_data_ok = s_data_ok;
  assign bus_fx.s_rdata = s_rdata;        assign bus_rr.s_rdata = s_rdata;

  sram_like_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4),
                      .ARB_MODE(ARB_FIXED)) u_fx (
    .clk(clk), .reset(reset), .bus(bus_fx), .outstanding_o(out_fx), .err_o(err_fx));
  sram_like_arbiter #(.NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .MAX_OUTSTANDING(4),
                      .ARB_MODE(ARB_RR)) u_rr (
    .clk(clk), .reset(reset), .bus(bus_rr), .outstanding_o(out_rr), .err_o(err_rr));

  typedef struct {
    logic rst; logic [1:0] req; logic sao, sdo; logic [31:0] rd;
    logic sreq; logic [1:0] aok, dok; logic [2:0] outs; logic err;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t V(input logic rst, input logic [1:0] req, input logic sao, input logic sdo,
                             input logic [31:0] rd, input logic sreq, input logic [1:0] aok,
                             input logic [1:0] dok, input logic [2:0] outs, input logic err);
    vec_t v;
    v.rst = rst; v.req = req; v.sao = sao; v.sdo = sdo; v.rd = rd;
    v.sreq = sreq; v.aok = aok; v.dok = dok; v.outs = outs; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst_v, input logic [1:0] req, input logic sao,
                       input logic sdo, input logic [31:0] rd);
    @(posedge clk); #1;
    reset = rst_v; m_req = req; s_addr_ok = sao; s_data_ok = sdo; s_rdata = rd;
    @(negedge clk);
  endtask

  logic [1:0] rr_exp [4];

  initial begin
    //                rst req  sao sdo rdata          sreq aok   dok   out err
    vecs.push_back(V(1, 2'b11, 1, 1, 32'h0,          0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(V(1, 2'b00, 0, 0, 32'h0,          0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(V(0, 2'b01, 1, 0, 32'h0,          1, 2'b01, 2'b00, 0, 0));
    vecs.push_back(V(0, 2'b00, 0, 0, 32'h0,          0, 2'b00, 2'b00, 1, 0));
    vecs.push_back(V(0, 2'b00, 0, 1, 32'hdeadbeef,   0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(V(0, 2'b00, 0, 0, 32'h0,          0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(V(0, 2'b11, 1, 0, 32'h0,          1, 2'b10, 2'b00, 0, 0));
    vecs.push_back(V(0, 2'b11, 1, 0, 32'h0,          1, 2'b10, 2'b00, 1, 0));
    vecs.push_back(V(0, 2'b11, 1, 0, 32'h0,          1, 2'b10, 2'b00, 2, 0));
    vecs.push_back(V(0, 2'b11, 1, 0, 32'h0,          1, 2'b10, 2'b00, 3, 0));
    vecs.push_back(V(0, 2'b11, 1, 0, 32'h0,          0, 2'b00, 2'b00, 4, 0));
    vecs.push_back(V(0, 2'b11, 1, 1, 32'h11,         0, 2'b00, 2'b10, 4, 0));
    vecs.push_back(V(0, 2'b11, 1, 0, 32'h0,          1, 2'b10, 2'b00, 3, 0));
    vecs.push_back(V(0, 2'b00, 0, 1, 32'h13,         0, 2'b00, 2'b10, 4, 0));
    vecs.push_back(V(0, 2'b00, 0, 1, 32'h14,         0, 2'b00, 2'b10, 3, 0));
    vecs.push_back(V(0, 2'b00, 0, 1, 32'h15,         0, 2'b00, 2'b10, 2, 0));
    vecs.push_back(V(0, 2'b00, 0, 1, 32'h16,         0, 2'b00, 2'b10, 1, 0));
    vecs.push_back(V(0, 2'b01, 1, 0, 32'h0,          1, 2'b01, 2'b00, 0, 0));
    vecs.push_back(V(0, 2'b10, 1, 0, 32'h0,          1, 2'b10, 2'b00, 1, 0));
    vecs.push_back(V(0, 2'b01, 1, 0, 32'h0,          1, 2'b01, 2'b00, 2, 0));
    vecs.push_back(V(0, 2'b00, 0, 1, 32'h20,         0, 2'b00, 2'b01, 3, 0));
    vecs.push_back(V(0, 2'b00, 0, 1, 32'h21,         0, 2'b00, 2'b10, 2, 0));
    vecs.push_back(V(0, 2'b00, 0, 1, 32'h22,         0, 2'b00, 2'b01, 1, 0));
    vecs.push_back(V(0, 2'b00, 0, 0, 32'h0,          0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(V(0, 2'b00, 0, 1, 32'h24,         0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(V(0, 2'b00, 0, 0, 32'h0,          0, 2'b00, 2'b00, 0, 1));
    vecs.push_back(V(0, 2'b01, 1, 0, 32'h0,          1, 2'b01, 2'b00, 0, 1));
    vecs.push_back(V(0, 2'b01, 1, 0, 32'h0,          1, 2'b01, 2'b00, 1, 1));
    vecs.push_back(V(1, 2'b01, 1, 0, 32'h0,          0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(V(0, 2'b00, 0, 0, 32'h0,          0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(V(0, 2'b00, 0, 1, 32'h30,         0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(V(0, 2'b00, 0, 0, 32'h0,          0, 2'b00, 2'b00, 0, 1));
    vecs.push_back(V(1, 2'b00, 0, 0, 32'h0,          0, 2'b00, 2'b00, 0, 0));
    vecs.push_back(V(0, 2'b00, 0, 0, 32'h0,          0, 2'b00, 2'b00, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].sao, vecs[i].sdo, vecs[i].rd);
      chk($sformatf("v%0d s_req", i), 32'(bus_fx.s_req), 32'(vecs[i].sreq));
      chk($sformatf("v%0d m_addr_ok", i), 32'(bus_fx.m_addr_ok), 32'(vecs[i].aok));
      chk($sformatf("v%0d m_data_ok", i), 32'(bus_fx.m_data_ok), 32'(vecs[i].dok));
      chk($sformatf("v%0d outstanding", i), 32'(out_fx), 32'(vecs[i].outs));
      chk($sformatf("v%0d err", i), 32'(err_fx), 32'(vecs[i].err));
      if (vecs[i].sdo) chk($sformatf("v%0d m_rdata", i), bus_fx.m_rdata, vecs[i].rd);
    end

    // Round-robin: pointer starts at 0, so grants go 0,1,0,1 and responses follow.
    rr_exp[0] = 2'b01; rr_exp[1] = 2'b10; rr_exp[2] = 2'b01; rr_exp[3] = 2'b10;
    drive(1, 2'b00, 0, 0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      drive(0, 2'b11, 1, 0, 32'h0);
      chk($sformatf("rr grant%0d", k), 32'(bus_rr.m_addr_ok), 32'(rr_exp[k]));
      chk($sformatf("fx grant%0d", k), 32'(bus_fx.m_addr_ok), 32'h2);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 2'b00, 0, 1, 32'h0);
      chk($sformatf("rr resp%0d", k), 32'(bus_rr.m_data_ok), 32'(rr_exp[k]));
    end
    drive(0, 2'b00, 0, 0, 32'h0);
    chk("rr drained", 32'(out_rr), 32'h0);
    chk("rr err", 32'(err_rr), 32'h0);

    // Lock: master 0 stalls, master 1 joins; request must not switch until accepted.
    drive(1, 2'b00, 0, 0, 32'h0);
    drive(0, 2'b01, 0, 0, 32'h0);
    chk("lock s_req", 32'(bus_fx.s_req), 32'h1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) drive(0, 2'b11, 0, 0, 32'h0);
      chk($sformatf("lock addr%0d", k), bus_fx.s_addr, 32'h1c00_0000);
      chk($sformatf("lock wr%0d", k), 32'(bus_fx.s_wr), 32'h0);
      chk($sformatf("lock aok%0d", k), 32'(bus_fx.m_addr_ok), 32'h0);
    end
    drive(0, 2'b11, 1, 0, 32'h0);
    chk("lock accept", 32'(bus_fx.m_addr_ok), 32'h1);
    drive(0, 2'b11, 1, 0, 32'h0);
    chk("post-lock aok", 32'(bus_fx.m_addr_ok), 32'h2);
    chk("post-lock addr", bus_fx.s_addr, 32'h8000_0100);
    chk("post-lock wr", 32'(bus_fx.s_wr), 32'h1);
    chk("post-lock wdata", bus_fx.s_wdata, 32'hcafe_f00d);
    chk("post-lock size", 32'(bus_fx.s_size), 32'h1);
    chk("post-lock wstrb", 32'(bus_fx.s_wstrb), 32'hf);

    // Withdrawn request while locked: err rises, lock released next cycle.
    drive(1, 2'b00, 0, 0, 32'h0);
    drive(0, 2'b10, 0, 0, 32'h0);
    chk("wd s_req", 32'(bus_fx.s_req), 32'h1);
    drive(0, 2'b00, 0, 0, 32'h0);
    chk("wd drop s_req", 32'(bus_fx.s_req), 32'h0);
    chk("wd err pre", 32'(err_fx), 32'h0);
    drive(0, 2'b01, 1, 0, 32'h0);
    chk("wd released", 32'(bus_fx.m_addr_ok), 32'h1);
    chk("wd err", 32'(err_fx), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
